// File: rtl/mem_pkg.sv
// Shared definitions for the load/store path: access size codes, FSM states
// and the alignment rule that decides whether a request is legal.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_RESP_ERR
    } state_t;

    // Halves must sit on even addresses, words on multiples of four; size 11 is never legal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: extracts and extends load data from a RAM word and
// merges right-aligned store data into a RAM word (little-endian lanes).
module mem_lane_fmt
    import mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    size,
    input  logic          zero_ext,
    input  logic [1:0]    lane,
    input  logic [DW-1:0] word,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] load_data,
    output logic [DW-1:0] merged
);

    logic [4:0]    shamt;
    logic [DW-1:0] shifted;
    logic [DW-1:0] lane_mask;
    logic [DW-1:0] wdata_sh;

    assign shamt    = {lane, 3'b000};
    assign shifted  = word >> shamt;
    assign wdata_sh = wdata << shamt;

    // NOTE: every output gets a default first, so no path through the case infers a latch.
    always_comb begin
        load_data = word;
        lane_mask = '1;
        case (size)
            SZ_B: begin
                load_data = zero_ext ? {{(DW-8){1'b0}}, shifted[7:0]}
                                     : {{(DW-8){shifted[7]}}, shifted[7:0]};
                lane_mask = {{(DW-8){1'b0}}, 8'hFF} << shamt;
            end
            SZ_H: begin
                load_data = zero_ext ? {{(DW-16){1'b0}}, shifted[15:0]}
                                     : {{(DW-16){shifted[15]}}, shifted[15:0]};
                lane_mask = {{(DW-16){1'b0}}, 16'hFFFF} << shamt;
            end
            default: begin
                load_data = word;
                lane_mask = '1;
            end
        endcase
    end

    assign merged = (word & ~lane_mask) | (wdata_sh & lane_mask);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of the word-wide data port of the shared RAM.
// One request at a time; sub-word stores become a read-modify-write pair.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter  int DW        = 32,
    parameter  int MEM_DEPTH = 65536,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [31:0]   req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          ram_ren_o,
    output logic [AW-1:0] ram_raddr_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic          ram_wen_o,
    output logic [AW-1:0] ram_waddr_o,
    output logic [DW-1:0] ram_wdata_o
);

    state_t        state;
    logic          we_q;
    logic [1:0]    size_q;
    logic          zext_q;
    logic [1:0]    lane_q;
    logic [DW-1:0] wdata_q;

    logic [AW-1:0] word_idx;
    logic [DW-1:0] load_data;
    logic [DW-1:0] merged;
    logic          unused_addr_hi;

    // Address bits above the RAM range are dropped, so accesses wrap.
    assign word_idx       = req_addr_i[AW+1:2];
    assign unused_addr_hi = ^req_addr_i[31:AW+2];

    mem_lane_fmt #(.DW(DW)) u_lane_fmt (
        .size      (size_q),
        .zero_ext  (zext_q),
        .lane      (lane_q),
        .word      (ram_rdata_i),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            ram_ren_o   <= 1'b0;
            ram_wen_o   <= 1'b0;
            ram_raddr_o <= '0;
            ram_waddr_o <= '0;
            ram_wdata_o <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            zext_q      <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            ram_ren_o   <= 1'b0;
            ram_wen_o   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        we_q        <= req_we_i;
                        size_q      <= req_size_i;
                        zext_q      <= req_unsigned_i;
                        lane_q      <= req_addr_i[1:0];
                        wdata_q     <= req_wdata_i;
                        req_ready_o <= 1'b0;
                        if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
                            state       <= ST_RESP_ERR;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            state       <= ST_ACCESS;
                            ram_raddr_o <= word_idx;
                            ram_waddr_o <= word_idx;
                            if (req_we_i && req_size_i == SZ_W) begin
                                ram_wen_o   <= 1'b1;
                                ram_wdata_o <= req_wdata_i;
                            end else begin
                                ram_ren_o <= 1'b1;
                            end
                        end
                    end
                end

                ST_ACCESS: begin
                    if (!we_q) begin
                        rsp_rdata_o <= load_data;
                        rsp_valid_o <= 1'b1;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (size_q == SZ_W) begin
                        rsp_rdata_o <= '0;
                        rsp_valid_o <= 1'b1;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        // The merged word is captured in the write-data register itself.
                        ram_wdata_o <= merged;
                        ram_wen_o   <= 1'b1;
                        state       <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    rsp_rdata_o <= '0;
                    rsp_valid_o <= 1'b1;
                    req_ready_o <= 1'b1;
                    state       <= ST_IDLE;
                end

                default: begin
                    req_ready_o <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
